// File: rtl/fetchflare_wrr_arbiter_pref.sv
// Weighted round-robin arbiter for the FetchFlare prefetch memory port: registered
// one-hot grant with accept handshake, per-requester burst credit and atomic lock.
module fetchflare_wrr_arbiter_pref #(
    parameter int ARBITER_WIDTH = 4,
    parameter int WEIGHT_W      = 4,
    parameter bit LOCK_EN       = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ARBITER_WIDTH-1:0]            request,
    input  logic [ARBITER_WIDTH*WEIGHT_W-1:0]   weight,
    input  logic                                lock,
    input  logic                                grant_ack,
    output logic [ARBITER_WIDTH-1:0]            grant,
    output logic                                grant_vld,
    output logic [$clog2(ARBITER_WIDTH)-1:0]    grant_idx
);
    localparam int IDX_W = $clog2(ARBITER_WIDTH);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t                                   state;
    logic [WEIGHT_W-1:0]                      credit;
    logic [ARBITER_WIDTH-1:0]                 pr;
    logic [ARBITER_WIDTH-1:0][WEIGHT_W-1:0]   weight_arr;

    logic [ARBITER_WIDTH-1:0]                 masked;
    logic [ARBITER_WIDTH-1:0]                 win_onehot;
    logic [ARBITER_WIDTH-1:0]                 pr_next;
    logic [IDX_W-1:0]                         win_idx;
    logic                                     any_req;
    logic                                     owner_req;
    logic                                     lock_eff;
    logic                                     xfer;
    logic                                     rearb;

    function automatic logic [IDX_W-1:0] lowest(input logic [ARBITER_WIDTH-1:0] v);
        lowest = '0;
        for (int i = ARBITER_WIDTH-1; i >= 0; i--)
            if (v[i]) lowest = IDX_W'(i);
    endfunction

    assign weight_arr = weight;
    assign masked     = request & pr;
    assign any_req    = |request;
    assign win_idx    = (|masked) ? lowest(masked) : lowest(request);

    genvar g;
    generate
        for (g = 0; g < ARBITER_WIDTH; g++) begin : g_lane
            assign win_onehot[g] = (win_idx == IDX_W'(g));
            assign pr_next[g]    = (IDX_W'(g) > win_idx);
        end
    endgenerate

    assign owner_req = grant_vld & request[grant_idx];
    assign lock_eff  = LOCK_EN & lock;
    assign xfer      = grant_vld & grant_ack & owner_req;
    // Owner walks away, or its unlocked burst just spent the last credit.
    assign rearb     = !owner_req || (xfer && !lock_eff && credit == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            credit    <= '0;
            pr        <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        grant     <= win_onehot;
                        grant_vld <= 1'b1;
                        grant_idx <= win_idx;
                        credit    <= weight_arr[win_idx];
                        pr        <= pr_next;
                    end
                end
                default: begin
                    if (rearb) begin
                        // pr already excludes the owner, so it only wins again if alone.
                        if (any_req) begin
                            state     <= GRANT;
                            grant     <= win_onehot;
                            grant_vld <= 1'b1;
                            grant_idx <= win_idx;
                            credit    <= weight_arr[win_idx];
                            pr        <= pr_next;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            grant_vld <= 1'b0;
                            grant_idx <= '0;
                            credit    <= '0;
                        end
                    end else if (xfer) begin
                        if (lock_eff) begin
                            state <= LOCKED;
                        end else begin
                            state  <= GRANT;
                            credit <= credit - 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetchflare_wrr_arbiter_pref.sv
// Directed bench: stimulus pushes the expected grant for the next cycle into a queue,
// a negedge monitor pops and compares whatever the arbiter presents.
module tb_fetchflare_wrr_arbiter_pref;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  request = '0;
    logic [15:0] weight = '0;
    logic        lock = 1'b0;
    logic        grant_ack = 1'b0;
    logic [3:0]  grant;
    logic        grant_vld;
    logic [1:0]  grant_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tst = 0;
    int stp = 0;

    typedef struct {
        int         cyc;
        logic       vld;
        logic [1:0] idx;
        int         tst;
        int         stp;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    fetchflare_wrr_arbiter_pref #(
        .ARBITER_WIDTH(4),
        .WEIGHT_W(4),
        .LOCK_EN(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .weight(weight),
        .lock(lock),
        .grant_ack(grant_ack),
        .grant(grant),
        .grant_vld(grant_vld),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int t, input int s, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s test=%0d step=%0d actual=%0h expected=%0h", nm, t, s, act, expv);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            chk("grant_vld", mon_e.tst, mon_e.stp, 32'(grant_vld), 32'(mon_e.vld));
            chk("grant_idx", mon_e.tst, mon_e.stp, 32'(grant_idx), 32'(mon_e.vld ? mon_e.idx : 2'd0));
            chk("grant", mon_e.tst, mon_e.stp, 32'(grant),
                32'(mon_e.vld ? (4'b0001 << mon_e.idx) : 4'b0000));
        end
    end

    // Called just after a rising edge; drives inputs and predicts the next registered grant.
    task automatic step(input logic [3:0] rq, input logic ak, input logic lk,
                        input logic ev, input logic [1:0] ei);
        exp_t e;
        request   = rq;
        grant_ack = ak;
        lock      = lk;
        e.cyc = cyc + 1;
        e.vld = ev;
        e.idx = ei;
        e.tst = tst;
        e.stp = stp;
        q.push_back(e);
        stp++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset     = 1'b0;
        request   = '0;
        grant_ack = 1'b0;
        lock      = 1'b0;
        #1;
        chk("rst_grant", tst, stp, 32'(grant), 32'h0);
        chk("rst_vld", tst, stp, 32'(grant_vld), 32'h0);
        chk("rst_idx", tst, stp, 32'(grant_idx), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: equal weights, full request -> strict rotation
        tst = 1; stp = 0; weight = 16'h0000;
        do_reset();
        step(4'b1111, 1, 0, 1, 0);
        step(4'b1111, 1, 0, 1, 1);
        step(4'b1111, 1, 0, 1, 2);
        step(4'b1111, 1, 0, 1, 3);
        step(4'b1111, 1, 0, 1, 0);
        step(4'b1111, 1, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0);

        // 2: weight[1]=2 -> 0,1,1,1,0,1,1,1
        tst = 2; stp = 0; weight = 16'h0020;
        do_reset();
        step(4'b0011, 1, 0, 1, 0);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0011, 1, 0, 1, 0);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0);

        // 3: owner 2 held through 5 cycles without ack
        tst = 3; stp = 0; weight = 16'h0000;
        do_reset();
        step(4'b1111, 1, 0, 1, 0);
        step(4'b1111, 1, 0, 1, 1);
        step(4'b1111, 1, 0, 1, 2);
        for (int i = 0; i < 5; i++) step(4'b1111, 0, 0, 1, 2);
        step(4'b1111, 1, 0, 1, 3);
        step(4'b0000, 0, 0, 0, 0);

        // 4: lock keeps owner 0 for three extra transfers
        tst = 4; stp = 0; weight = 16'h0000;
        do_reset();
        step(4'b0011, 1, 0, 1, 0);
        step(4'b0011, 1, 1, 1, 0);
        step(4'b0011, 1, 1, 1, 0);
        step(4'b0011, 1, 1, 1, 0);
        step(4'b0011, 1, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0);

        // 5: owner drops before ack; non-owner never preempts
        tst = 5; stp = 0; weight = 16'h0000;
        do_reset();
        step(4'b1000, 0, 0, 1, 3);
        step(4'b1001, 0, 0, 1, 3);
        step(4'b0001, 0, 0, 1, 0);
        step(4'b1000, 0, 0, 1, 3);
        step(4'b0000, 1, 0, 0, 0);

        // 6: reset mid-burst, then full weight reloaded; later weight change ignored
        tst = 6; stp = 0; weight = 16'h3000;
        do_reset();
        step(4'b1000, 1, 0, 1, 3);
        step(4'b1000, 1, 0, 1, 3);
        do_reset();
        step(4'b1000, 1, 0, 1, 3);
        weight = 16'h0000;
        step(4'b1001, 1, 0, 1, 3);
        step(4'b1001, 1, 0, 1, 3);
        step(4'b1001, 1, 0, 1, 3);
        step(4'b1001, 1, 0, 1, 0);
        step(4'b0000, 0, 0, 0, 0);

        // 7: maximum weight -> 16 consecutive transfers
        tst = 7; stp = 0; weight = 16'h00F0;
        do_reset();
        step(4'b0010, 1, 0, 1, 1);
        for (int i = 0; i < 15; i++) step(4'b0011, 1, 0, 1, 1);
        step(4'b0011, 1, 0, 1, 0);
        step(4'b0000, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("drain", tst, stp, 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
